ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the 32-bit ALU; registers the ALU result, Zero flag and the instruction's memory/writeback controls for the MEM stage.
- Resolves conditional branches from the ALU compare result (1 = condition true) and issues a one-cycle PC redirect plus front-end flush.
- Squashes the in-flight shadow instructions after a taken branch using a small state machine.
- Drives the EX/MEM forwarding path.

Parameters:
- WIDTH, 32, datapath width of result, store data and branch target.
- REG_AW, 5, register-file address width.
- SHADOW, 2, number of younger valid instructions squashed after a taken branch (1..7).
- CNT_W, 16, width of the saturating taken-branch counter.

Ports:
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous reset, active-low.
- Stall  in  1  hold: no register, FSM or counter changes.
- Flush  in  1  squash the entry being captured this cycle (bubble in).
- In_Valid  in  1  EX holds a real instruction.
- ALUResult  in  WIDTH  ALU output.
- Zero  in  1  ALU zero flag.
- StoreData  in  WIDTH  rt value for stores.
- BranchTarget  in  WIDTH  computed branch PC.
- Dest  in  REG_AW  destination register.
- RegWrite, MemRead, MemWrite, Branch  in  1 each  decoded controls.
- Out_Valid  out  1  MEM-stage entry valid.
- Out_ALUResult  out  WIDTH  registered result / address.
- Out_Zero  out  1  registered Zero.
- Out_StoreData  out  WIDTH  registered store data.
- Out_Dest  out  REG_AW  registered destination.
- Out_RegWrite, Out_MemRead, Out_MemWrite  out  1 each  controls, forced 0 when Out_Valid=0.
- PCSrc  out  1  one-cycle redirect pulse.
- PCTarget  out  WIDTH  redirect target, valid while PCSrc=1.
- BranchFlush  out  1  one-cycle flush of IF/ID and ID/EX, coincident with PCSrc.
- Fwd_Valid  out  1  Out_Valid & Out_RegWrite & (Out_Dest != 0).
- Fwd_Dest  out  REG_AW  equals Out_Dest.
- Fwd_Data  out  WIDTH  equals Out_ALUResult.
- TakenCount  out  CNT_W  saturating count of taken branches.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - All outputs 0, FSM = RUN, shadow counter 0, TakenCount 0.
  - Reset asserted mid-redirect kills the pulse immediately.
- Priority each rising edge: Reset > Stall > Flush > capture.
- Effective valid: EV = In_Valid & ~Flush & (state==RUN).
  - In SHADOW state, incoming entries are captured as bubbles.
- Capture (Stall=0):
  - Out_Valid <= EV.
  - Data and Dest fields are loaded unconditionally.
  - Control outputs <= control & EV.
- Branch taken: Take = EV & Branch & (ALUResult != 0).
  - On Take, next cycle PCSrc=1, BranchFlush=1, PCTarget=BranchTarget.
  - Both pulses are exactly one cycle; PCTarget holds its value afterwards.
  - Branch entry itself: Out_Valid=1, Out_RegWrite=0, Out_MemRead=0, Out_MemWrite=0, regardless of inputs.
- FSM:
  - RUN -> SHADOW on Take; counter <= SHADOW.
  - In SHADOW, each unstalled cycle with In_Valid=1 decrements the counter; the entry is squashed.
  - Cycles with In_Valid=0 do not decrement.
  - Counter reaching 0 -> RUN; the next valid input is captured normally.
  - Flush=1 while in SHADOW forces RUN and clears the counter; the captured entry is a bubble.
- Stall=1:
  - All registers, FSM and TakenCount hold.
  - PCSrc and BranchFlush drop to 0 after their single cycle even if Stall stays high; no repeat pulse.
  - A branch presented during Stall is evaluated on the first unstalled edge.
- Stall=1 and Flush=1 together: stall wins and Flush is ignored. The upstream stage re-asserts Flush if still needed.
- A branch arriving while in SHADOW is squashed and never taken.
- TakenCount increments on each Take and saturates at all-ones (no wrap).
- Out_Zero is registered as-is and is not used for branch resolution.
- Latency: one cycle from EX to MEM outputs and from EX to redirect.

Test Plan:
- Reset, then In_Valid=1, ALUResult=0x0000_0010, Dest=5, RegWrite=1 -> next cycle Out_Valid=1, Out_ALUResult=0x10, Fwd_Valid=1, Fwd_Dest=5. Same with Dest=0 -> Fwd_Valid=0.
- Branch=1, ALUResult=1, BranchTarget=0x0040_0020, then 3 valid ALU ops -> PCSrc and BranchFlush high exactly one cycle with PCTarget=0x0040_0020; next 2 ops have Out_Valid=0; 3rd op has Out_Valid=1; TakenCount=1.
- Branch=1, ALUResult=0 -> PCSrc stays 0 and FSM stays RUN; a following op is captured normally.
- Taken branch, then Stall=1 for 3 cycles during SHADOW -> PCSrc pulses once only; outputs and counter frozen; after release, 2 valid inputs are squashed.
- In SHADOW, assert Flush with In_Valid=1 -> bubble captured, FSM returns to RUN; the next valid op is captured with Out_Valid=1.
- Reset_n low mid-stream (PCSrc=1, Out_Valid=1) -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, post-branch shadow squash and forwarding.
// A taken branch produces a one-cycle redirect/flush pulse and squashes the next SHADOW valid entries.
module ex_mem_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned SHADOW = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              In_Valid,
    input  logic [WIDTH-1:0]  ALUResult,
    input  logic              Zero,
    input  logic [WIDTH-1:0]  StoreData,
    input  logic [WIDTH-1:0]  BranchTarget,
    input  logic [REG_AW-1:0] Dest,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    output logic              Out_Valid,
    output logic [WIDTH-1:0]  Out_ALUResult,
    output logic              Out_Zero,
    output logic [WIDTH-1:0]  Out_StoreData,
    output logic [REG_AW-1:0] Out_Dest,
    output logic              Out_RegWrite,
    output logic              Out_MemRead,
    output logic              Out_MemWrite,
    output logic              PCSrc,
    output logic [WIDTH-1:0]  PCTarget,
    output logic              BranchFlush,
    output logic              Fwd_Valid,
    output logic [REG_AW-1:0] Fwd_Dest,
    output logic [WIDTH-1:0]  Fwd_Data,
    output logic [CNT_W-1:0]  TakenCount
);

    typedef enum logic [0:0] {StRun, StShadow} state_e;

    localparam logic [2:0] ShadowInit = 3'(SHADOW);

    state_e            r_state;
    logic [2:0]        r_shadow_cnt;
    logic              r_valid;
    logic [WIDTH-1:0]  r_alu_result;
    logic              r_zero;
    logic [WIDTH-1:0]  r_store_data;
    logic [REG_AW-1:0] r_dest;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_pc_src;
    logic [WIDTH-1:0]  r_pc_target;
    logic              r_branch_flush;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic w_ev;
    logic w_take;

    assign w_ev   = In_Valid & ~Flush & (r_state == StRun);
    assign w_take = w_ev & Branch & (ALUResult != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= StRun;
            r_shadow_cnt   <= '0;
            r_valid        <= 1'b0;
            r_alu_result   <= '0;
            r_zero         <= 1'b0;
            r_store_data   <= '0;
            r_dest         <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_pc_src       <= 1'b0;
            r_pc_target    <= '0;
            r_branch_flush <= 1'b0;
            r_taken_cnt    <= '0;
        end else begin
            // Redirect pulses always self-clear, even while stalled
            r_pc_src       <= 1'b0;
            r_branch_flush <= 1'b0;
            if (!Stall) begin
                r_valid      <= w_ev;
                r_alu_result <= ALUResult;
                r_zero       <= Zero;
                r_store_data <= StoreData;
                r_dest       <= Dest;
                r_reg_write  <= RegWrite & w_ev & ~w_take;
                r_mem_read   <= MemRead & w_ev & ~w_take;
                r_mem_write  <= MemWrite & w_ev & ~w_take;
                if (w_take) begin
                    r_pc_src       <= 1'b1;
                    r_branch_flush <= 1'b1;
                    r_pc_target    <= BranchTarget;
                    if (r_taken_cnt != '1) begin
                        r_taken_cnt <= r_taken_cnt + 1'b1;
                    end
                end
                case (r_state)
                    StRun: begin
                        if (w_take) begin
                            r_state      <= StShadow;
                            r_shadow_cnt <= ShadowInit;
                        end
                    end
                    StShadow: begin
                        if (Flush) begin
                            r_state      <= StRun;
                            r_shadow_cnt <= '0;
                        end else if (In_Valid) begin
                            r_shadow_cnt <= r_shadow_cnt - 3'd1;
                            if (r_shadow_cnt <= 3'd1) begin
                                r_state <= StRun;
                            end
                        end
                    end
                    default: r_state <= StRun;
                endcase
            end
        end
    end

    assign Out_Valid     = r_valid;
    assign Out_ALUResult = r_alu_result;
    assign Out_Zero      = r_zero;
    assign Out_StoreData = r_store_data;
    assign Out_Dest      = r_dest;
    assign Out_RegWrite  = r_reg_write;
    assign Out_MemRead   = r_mem_read;
    assign Out_MemWrite  = r_mem_write;
    assign PCSrc         = r_pc_src;
    assign PCTarget      = r_pc_target;
    assign BranchFlush   = r_branch_flush;
    assign TakenCount    = r_taken_cnt;

    assign Fwd_Valid = r_valid & r_reg_write & (r_dest != '0);
    assign Fwd_Dest  = r_dest;
    assign Fwd_Data  = r_alu_result;

endmodule
